// File: rtl/tb_bus_pkg.sv
// Shared types and widths for the two-phase memory bus driver.
package tb_bus_pkg;

  localparam int unsigned BUS_ADDR_W = 16;
  localparam int unsigned BUS_DATA_W = 8;

  typedef enum logic [2:0] {IDLE, PH1, GAP1, PH2, GAP2, DONE} bus_state_e;

  typedef struct packed {
    logic                  we;
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/phase_timer.sv
// Down-counter that times one phi phase; last_o is high while the count is zero.
module phase_timer #(
  parameter int unsigned PHASE_CYC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic last_o
);

  localparam int unsigned CNT_W = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(PHASE_CYC - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= LOAD_VAL;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/mem_bus_phase_gen.sv
// Turns a valid/ready read or write request into one phi1 -> phi2 bus cycle
// on the two-phase test memory and returns read data on a one-cycle strobe.
module mem_bus_phase_gen
  import tb_bus_pkg::*;
#(
  parameter int unsigned PHASE_CYC = 2,
  parameter int unsigned ADDR_W    = BUS_ADDR_W,
  parameter int unsigned DATA_W    = BUS_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              halt,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              phi1,
  output logic              phi2,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_read_e,
  input  logic [DATA_W-1:0] bus_rdata
);

  if (PHASE_CYC < 2) begin : g_phase_cyc_chk
    $error("mem_bus_phase_gen: PHASE_CYC must be >= 2");
  end

  bus_state_e        state_q;
  bus_req_t          req_q;
  logic              phi1_q;
  logic              phi2_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  logic accept_c;
  logic timer_load_c;
  logic timer_en_c;
  logic timer_last;

  assign accept_c     = (state_q == IDLE) && req_valid && req_ready_q;
  assign timer_load_c = accept_c || (state_q == GAP1);
  assign timer_en_c   = (state_q == PH1) || (state_q == PH2);

  phase_timer #(
    .PHASE_CYC (PHASE_CYC)
  ) u_phase_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (timer_load_c),
    .en_i   (timer_en_c),
    .last_o (timer_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      phi1_q      <= 1'b0;
      phi2_q      <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      // Hold the bus while phi2 falls so an in-flight write commits cleanly.
      if (!phi2_q) begin
        req_q <= '0;
      end
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          req_ready_q <= ~halt;
          if (accept_c) begin
            req_q.we   <= req_we;
            req_q.addr <= BUS_ADDR_W'(req_addr);
            if (req_we) begin
              req_q.wdata <= BUS_DATA_W'(req_wdata);
            end
            req_ready_q <= 1'b0;
            phi1_q      <= 1'b1;
            state_q     <= PH1;
          end
        end
        PH1: begin
          if (timer_last) begin
            phi1_q  <= 1'b0;
            state_q <= GAP1;
          end
        end
        GAP1: begin
          phi2_q  <= 1'b1;
          state_q <= PH2;
        end
        PH2: begin
          if (timer_last) begin
            if (!req_q.we) begin
              rsp_rdata_q <= bus_rdata;
            end
            phi2_q  <= 1'b0;
            state_q <= GAP2;
          end
        end
        GAP2: begin
          rsp_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          req_ready_q <= ~halt;
          state_q     <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign phi1       = phi1_q;
  assign phi2       = phi2_q;
  assign bus_addr   = ADDR_W'(req_q.addr);
  assign bus_wdata  = DATA_W'(req_q.wdata);
  assign bus_read_e = ~req_q.we;

endmodule

// File: tb/tb_mem_bus_phase_gen.sv
// Directed bench for mem_bus_phase_gen driving a behavioural two-phase memory.
module tb_mem_bus_phase_gen;

  localparam int LAT_EXP = 7;  // accept edge to the edge that samples rsp_valid
  localparam int GAP_EXP = 8;  // accept-to-accept spacing with req_valid held

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        halt;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        phi1;
  logic        phi2;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_read_e;
  logic [7:0]  bus_rdata;

  int checks = 0;
  int errors = 0;

  mem_bus_phase_gen #(
    .PHASE_CYC (2),
    .ADDR_W    (16),
    .DATA_W    (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .halt       (halt),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .phi1       (phi1),
    .phi2       (phi2),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_read_e (bus_read_e),
    .bus_rdata  (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 6502-style memory: read registered on phi2 rise, write on phi2 fall.
  logic [7:0] mem [0:65535];
  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'hFF;
    mem[16'h1234] = 8'hA5;
    bus_rdata = 8'h00;
  end
  always @(posedge phi2) if (bus_read_e) bus_rdata <= mem[bus_addr];
  always @(negedge phi2) if (!bus_read_e) mem[bus_addr] <= bus_wdata;

  // Edge monitor: accepts, responses, phase overlap and phase widths.
  int cyc = 0;
  int acc_q[$];
  int rsp_cnt = 0;
  int overlap = 0;
  int bad_width = 0;
  int phi_act = 0;
  int run1 = 0;
  int run2 = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (req_valid && req_ready) acc_q.push_back(cyc);
    if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    if (phi1 && phi2) overlap <= overlap + 1;
    if (phi1 || phi2) phi_act <= phi_act + 1;
    if (rst) begin
      run1 <= 0;
      run2 <= 0;
    end else begin
      run1 <= phi1 ? run1 + 1 : 0;
      run2 <= phi2 ? run2 + 1 : 0;
      if (!phi1 && run1 != 0 && run1 != 2) bad_width <= bad_width + 1;
      if (!phi2 && run2 != 0 && run2 != 2) bad_width <= bad_width + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_phi1"},       32'(phi1),       32'h0);
    chk({tag, "_phi2"},       32'(phi2),       32'h0);
    chk({tag, "_bus_read_e"}, 32'(bus_read_e), 32'h1);
    chk({tag, "_bus_addr"},   32'(bus_addr),   32'h0);
    chk({tag, "_bus_wdata"},  32'(bus_wdata),  32'h0);
    chk({tag, "_req_ready"},  32'(req_ready),  32'h0);
    chk({tag, "_rsp_valid"},  32'(rsp_valid),  32'h0);
    chk({tag, "_rsp_rdata"},  32'(rsp_rdata),  32'h0);
  endtask

  // Present a request and step through its accept edge.
  task automatic issue(input string tag, input logic we, input logic [15:0] addr,
                       input logic [7:0] wd);
    logic ok;
    req_we = we; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (req_ready) begin ok = 1'b1; break; end
      step();
    end
    chk({tag, "_accept"}, 32'(ok), 32'h1);
    step();
    req_valid = 1'b0;
  endtask

  // A value seen just after edge k is the one sampled at edge k+1.
  task automatic wait_rsp(input string tag, input logic we, input logic [15:0] addr);
    int lat = 0;
    int unstable = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus_addr !== addr || bus_read_e !== ~we) unstable++;
      if (rsp_valid) begin lat = i + 1; break; end
      step();
    end
    chk({tag, "_latency"}, 32'(lat), 32'(LAT_EXP));
    chk({tag, "_bus_stable"}, 32'(unstable), 32'h0);
  endtask

  task automatic do_req(input string tag, input logic we, input logic [15:0] addr,
                        input logic [7:0] wd, input logic [7:0] exp_rd);
    issue(tag, we, addr, wd);
    wait_rsp(tag, we, addr);
    chk({tag, "_rdata"}, 32'(rsp_rdata), 32'(exp_rd));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int n0;
    int p0;
    int r0;
    int g1;
    int g2;
    int rdy_seen;
    logic ok;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; halt = 1'b0;
    step(); step(); step();
    chk_reset("reset");
    rst = 1'b0;
    step();

    do_req("rd1234", 1'b0, 16'h1234, 8'h00, 8'hA5);
    do_req("wr0200", 1'b1, 16'h0200, 8'h5A, 8'hA5);  // write leaves rsp_rdata alone
    chk("mem_0200", 32'(mem[16'h0200]), 32'h5A);
    chk("mem_0201", 32'(mem[16'h0201]), 32'hFF);
    do_req("rd0200", 1'b0, 16'h0200, 8'h00, 8'h5A);

    // Three reads with req_valid held high.
    base = acc_q.size();
    req_we = 1'b0; req_addr = 16'h1234; req_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (acc_q.size() >= base + 3) break;
      step();
    end
    req_valid = 1'b0;
    chk("b2b_accepts", 32'(acc_q.size() - base), 32'h3);
    g1 = (acc_q.size() >= base + 3) ? acc_q[base+1] - acc_q[base]   : -1;
    g2 = (acc_q.size() >= base + 3) ? acc_q[base+2] - acc_q[base+1] : -1;
    chk("b2b_gap1", 32'(g1), 32'(GAP_EXP));
    chk("b2b_gap2", 32'(g2), 32'(GAP_EXP));
    wait_rsp("b2b_last", 1'b0, 16'h1234);
    chk("b2b_rdata", 32'(rsp_rdata), 32'hA5);

    // halt in IDLE blocks accepts and phase activity.
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin ok = 1'b1; break; end
      step();
    end
    chk("halt_idle_ready", 32'(ok), 32'h1);
    halt = 1'b1;
    step();
    chk("halt_ready_drop", 32'(req_ready), 32'h0);
    req_valid = 1'b1;
    n0 = acc_q.size(); p0 = phi_act; rdy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (req_ready) rdy_seen++;
    end
    chk("halt_no_ready", 32'(rdy_seen), 32'h0);
    chk("halt_no_accept", 32'(acc_q.size() - n0), 32'h0);
    chk("halt_no_phi", 32'(phi_act - p0), 32'h0);
    halt = 1'b0;
    step();
    chk("halt_release_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = 1'b0;
    chk("halt_release_accept", 32'(acc_q.size() - n0), 32'h1);
    wait_rsp("halt_release", 1'b0, 16'h1234);

    // halt raised mid-cycle: cycle finishes, the next request waits for halt to drop.
    issue("halt_ph1", 1'b0, 16'h0200, 8'h00);
    halt = 1'b1;
    wait_rsp("halt_ph1", 1'b0, 16'h0200);
    chk("halt_ph1_rdata", 32'(rsp_rdata), 32'h5A);
    req_addr = 16'h1234; req_we = 1'b0; req_valid = 1'b1;
    n0 = acc_q.size();
    for (int i = 0; i < 10; i++) step();
    chk("halt_ph1_blocked", 32'(acc_q.size() - n0), 32'h0);
    chk("halt_ph1_ready", 32'(req_ready), 32'h0);
    halt = 1'b0;
    step(); step();
    req_valid = 1'b0;
    chk("halt_ph1_resume", 32'(acc_q.size() - n0), 32'h1);
    wait_rsp("halt_ph1_resume", 1'b0, 16'h1234);

    // Reset during PH2 of a write: phi2 falls, write commits, bus clears a cycle later.
    issue("rst_wr", 1'b1, 16'h0300, 8'h3C);
    for (int i = 0; i < 20; i++) begin
      if (phi2) break;
      step();
    end
    chk("rst_wr_in_ph2", 32'(phi2), 32'h1);
    r0 = rsp_cnt;
    rst = 1'b1;
    step();
    chk("rst1_phi1", 32'(phi1), 32'h0);
    chk("rst1_phi2", 32'(phi2), 32'h0);
    chk("rst1_addr_held", 32'(bus_addr), 32'h0300);
    chk("rst1_wdata_held", 32'(bus_wdata), 32'h3C);
    chk("rst1_read_e_held", 32'(bus_read_e), 32'h0);
    chk("rst1_mem_0300", 32'(mem[16'h0300]), 32'h3C);
    step();
    chk_reset("rst2");
    rst = 1'b0;
    step();
    chk("rst_no_rsp", 32'(rsp_cnt - r0), 32'h0);
    do_req("rd0300", 1'b0, 16'h0300, 8'h00, 8'h3C);

    chk("phi_overlap", 32'(overlap), 32'h0);
    chk("phase_width", 32'(bad_width), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
